// File: rtl/read_data_router_if.sv
// R-channel bundle between three AXI slaves and two AXI masters.
// Modport "slave" is the router's view (it is the slave of the R beats coming
// from S0..S2 and drives M0/M1); modport "master" is the surrounding fabric.
interface read_data_router_if #(
    parameter int DATA_W = 32,
    parameter int IDS_W  = 8,
    parameter int ID_W   = 4
);
    logic [IDS_W-1:0]  RID_S0, RID_S1, RID_S2;
    logic [DATA_W-1:0] RDATA_S0, RDATA_S1, RDATA_S2;
    logic [1:0]        RRESP_S0, RRESP_S1, RRESP_S2;
    logic              RLAST_S0, RLAST_S1, RLAST_S2;
    logic              RVALID_S0, RVALID_S1, RVALID_S2;
    logic              RREADY_S0, RREADY_S1, RREADY_S2;

    logic [ID_W-1:0]   RID_M0, RID_M1;
    logic [DATA_W-1:0] RDATA_M0, RDATA_M1;
    logic [1:0]        RRESP_M0, RRESP_M1;
    logic              RLAST_M0, RLAST_M1;
    logic              RVALID_M0, RVALID_M1;
    logic              RREADY_M0, RREADY_M1;

    modport slave (
        input  RID_S0, RID_S1, RID_S2, RDATA_S0, RDATA_S1, RDATA_S2,
        input  RRESP_S0, RRESP_S1, RRESP_S2, RLAST_S0, RLAST_S1, RLAST_S2,
        input  RVALID_S0, RVALID_S1, RVALID_S2,
        output RREADY_S0, RREADY_S1, RREADY_S2,
        output RID_M0, RID_M1, RDATA_M0, RDATA_M1, RRESP_M0, RRESP_M1,
        output RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1,
        input  RREADY_M0, RREADY_M1
    );

    modport master (
        output RID_S0, RID_S1, RID_S2, RDATA_S0, RDATA_S1, RDATA_S2,
        output RRESP_S0, RRESP_S1, RRESP_S2, RLAST_S0, RLAST_S1, RLAST_S2,
        output RVALID_S0, RVALID_S1, RVALID_S2,
        input  RREADY_S0, RREADY_S1, RREADY_S2,
        input  RID_M0, RID_M1, RDATA_M0, RDATA_M1, RRESP_M0, RRESP_M1,
        input  RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1,
        output RREADY_M0, RREADY_M1
    );
endinterface

// File: rtl/read_data_router.sv
// AXI R-channel router: S0/S1/S2 bursts back to M0/M1.
// One burst in flight; the winning slave is locked until its RLAST handshake,
// beats are steered by the master tag RID[7:4] and RID[3:0] is forwarded.
// Tag 4'b0001 -> M0, 4'b0010 -> M1, anything else is sunk (accepted, dropped).
// Optional feature: define RDR_RR_ARB_EN for round-robin arbitration;
// otherwise fixed priority S0 > S1 > S2.
module read_data_router #(
    parameter int DATA_W = 32,
    parameter int IDS_W  = 8,
    parameter int ID_W   = 4
) (
    input logic               clk,
    input logic               rst,
    read_data_router_if.slave io_bus
);
    localparam int TAG_W = IDS_W - ID_W;

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;
    typedef enum logic [1:0] {DST_M0, DST_M1, DST_SINK} dest_t;

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_grant, w_grant_nxt;
    dest_t             r_dest, w_dest_nxt;

    logic [2:0]        w_req;
    logic [2:0]        w_win;
    logic [TAG_W-1:0]  w_tag_win;
    logic              w_valid_g, w_last_g, w_ready_g, w_done;
    logic [ID_W-1:0]   w_id_g;
    logic [DATA_W-1:0] w_data_g;
    logic [1:0]        w_resp_g;

    function automatic dest_t f_decode(input logic [TAG_W-1:0] tag);
        if (tag == TAG_W'(1))      return DST_M0;
        else if (tag == TAG_W'(2)) return DST_M1;
        else                       return DST_SINK;
    endfunction

    assign w_req = {io_bus.RVALID_S2, io_bus.RVALID_S1, io_bus.RVALID_S0};

`ifdef RDR_RR_ARB_EN
    logic [1:0] r_rr_ptr;
    logic [1:0] w_idx;

    // Round-robin pick: first requester found scanning from r_rr_ptr upward
    always_comb begin
        w_win = '0;
        w_idx = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            w_idx = 2'((32'(r_rr_ptr) + k) % 3);
            if ((w_win == '0) && w_req[w_idx]) w_win[w_idx] = 1'b1;
        end
    end

    // Pointer moves past the served slave only when its burst completes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr <= '0;
        end else if (w_done) begin
            r_rr_ptr <= r_grant[0] ? 2'd1 : (r_grant[1] ? 2'd2 : 2'd0);
        end
    end
`else
    // Fixed priority pick: S0 > S1 > S2
    always_comb begin
        w_win = '0;
        if (w_req[0])      w_win = 3'b001;
        else if (w_req[1]) w_win = 3'b010;
        else if (w_req[2]) w_win = 3'b100;
    end
`endif

    // Master tag of the arbitration winner, decoded once per burst
    always_comb begin
        w_tag_win = '0;
        if (w_win[0])      w_tag_win = io_bus.RID_S0[IDS_W-1:ID_W];
        else if (w_win[1]) w_tag_win = io_bus.RID_S1[IDS_W-1:ID_W];
        else if (w_win[2]) w_tag_win = io_bus.RID_S2[IDS_W-1:ID_W];
    end

    // Select the signals of the locked slave
    always_comb begin
        w_valid_g = 1'b0;
        w_last_g  = 1'b0;
        w_id_g    = '0;
        w_data_g  = '0;
        w_resp_g  = '0;
        if (r_grant[0]) begin
            w_valid_g = io_bus.RVALID_S0;
            w_last_g  = io_bus.RLAST_S0;
            w_id_g    = io_bus.RID_S0[ID_W-1:0];
            w_data_g  = io_bus.RDATA_S0;
            w_resp_g  = io_bus.RRESP_S0;
        end else if (r_grant[1]) begin
            w_valid_g = io_bus.RVALID_S1;
            w_last_g  = io_bus.RLAST_S1;
            w_id_g    = io_bus.RID_S1[ID_W-1:0];
            w_data_g  = io_bus.RDATA_S1;
            w_resp_g  = io_bus.RRESP_S1;
        end else if (r_grant[2]) begin
            w_valid_g = io_bus.RVALID_S2;
            w_last_g  = io_bus.RLAST_S2;
            w_id_g    = io_bus.RID_S2[ID_W-1:0];
            w_data_g  = io_bus.RDATA_S2;
            w_resp_g  = io_bus.RRESP_S2;
        end
    end

    // FSM state, grant and destination registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_dest  <= DST_SINK;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_dest  <= w_dest_nxt;
        end
    end

    // Pass-through steering, ready return path and next-state decision
    always_comb begin
        io_bus.RVALID_M0 = 1'b0;
        io_bus.RVALID_M1 = 1'b0;
        io_bus.RLAST_M0  = 1'b0;
        io_bus.RLAST_M1  = 1'b0;
        io_bus.RID_M0    = '0;
        io_bus.RID_M1    = '0;
        io_bus.RDATA_M0  = '0;
        io_bus.RDATA_M1  = '0;
        io_bus.RRESP_M0  = '0;
        io_bus.RRESP_M1  = '0;
        w_ready_g        = 1'b0;
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_dest_nxt       = r_dest;

        if (r_state == ST_BUSY) begin
            case (r_dest)
                DST_M0: begin
                    io_bus.RVALID_M0 = w_valid_g;
                    io_bus.RLAST_M0  = w_last_g;
                    io_bus.RID_M0    = w_id_g;
                    io_bus.RDATA_M0  = w_data_g;
                    io_bus.RRESP_M0  = w_resp_g;
                    w_ready_g        = io_bus.RREADY_M0;
                end
                DST_M1: begin
                    io_bus.RVALID_M1 = w_valid_g;
                    io_bus.RLAST_M1  = w_last_g;
                    io_bus.RID_M1    = w_id_g;
                    io_bus.RDATA_M1  = w_data_g;
                    io_bus.RRESP_M1  = w_resp_g;
                    w_ready_g        = io_bus.RREADY_M1;
                end
                default: w_ready_g = 1'b1;
            endcase
        end

        w_done = (r_state == ST_BUSY) && w_valid_g && w_ready_g && w_last_g;

        case (r_state)
            ST_IDLE: begin
                if (w_req != '0) begin
                    w_state_nxt = ST_BUSY;
                    w_grant_nxt = w_win;
                    w_dest_nxt  = f_decode(w_tag_win);
                end
            end
            ST_BUSY: begin
                if (w_done) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    assign io_bus.RREADY_S0 = r_grant[0] & w_ready_g;
    assign io_bus.RREADY_S1 = r_grant[1] & w_ready_g;
    assign io_bus.RREADY_S2 = r_grant[2] & w_ready_g;
endmodule

// File: tb/tb_read_data_router.sv
// Directed bench for read_data_router: each vector drives one clock cycle of
// slave/master inputs and checks the combinational router outputs.
module tb_read_data_router;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    read_data_router_if #(.DATA_W(32), .IDS_W(8), .ID_W(4)) bus ();

    read_data_router #(.DATA_W(32), .IDS_W(8), .ID_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    typedef struct {
        logic        rn;
        logic [2:0]  v, l;
        logic [7:0]  id0, id1, id2;
        logic [31:0] d0, d1, d2;
        logic [1:0]  rm;
        logic [2:0]  ers;
        logic [1:0]  evm, elm;
        logic [3:0]  eid0, eid1;
        logic [31:0] ed0, ed1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rn, input logic [2:0] v, input logic [2:0] l,
        input logic [7:0] id0, input logic [7:0] id1, input logic [7:0] id2,
        input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
        input logic [1:0] rm, input logic [2:0] ers,
        input logic [1:0] evm, input logic [1:0] elm,
        input logic [3:0] eid0, input logic [3:0] eid1,
        input logic [31:0] ed0, input logic [31:0] ed1);
        vec_t t;
        t.rn = rn; t.v = v; t.l = l;
        t.id0 = id0; t.id1 = id1; t.id2 = id2;
        t.d0 = d0; t.d1 = d1; t.d2 = d2;
        t.rm = rm; t.ers = ers; t.evm = evm; t.elm = elm;
        t.eid0 = eid0; t.eid1 = eid1; t.ed0 = ed0; t.ed1 = ed1;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input string nm);
        @(negedge clk);
        rst = t.rn;
        {bus.RVALID_S2, bus.RVALID_S1, bus.RVALID_S0} = t.v;
        {bus.RLAST_S2, bus.RLAST_S1, bus.RLAST_S0}    = t.l;
        bus.RID_S0 = t.id0;  bus.RID_S1 = t.id1;  bus.RID_S2 = t.id2;
        bus.RDATA_S0 = t.d0; bus.RDATA_S1 = t.d1; bus.RDATA_S2 = t.d2;
        bus.RREADY_M0 = t.rm[0];
        bus.RREADY_M1 = t.rm[1];
        #1;
        chk({nm, ".rready_s"}, 32'({bus.RREADY_S2, bus.RREADY_S1, bus.RREADY_S0}), 32'(t.ers));
        chk({nm, ".rvalid_m"}, 32'({bus.RVALID_M1, bus.RVALID_M0}), 32'(t.evm));
        chk({nm, ".rlast_m"}, 32'({bus.RLAST_M1, bus.RLAST_M0} & t.evm), 32'(t.elm));
        if (t.evm[0]) begin
            chk({nm, ".rid_m0"}, 32'(bus.RID_M0), 32'(t.eid0));
            chk({nm, ".rdata_m0"}, bus.RDATA_M0, t.ed0);
        end
        if (t.evm[1]) begin
            chk({nm, ".rid_m1"}, 32'(bus.RID_M1), 32'(t.eid1));
            chk({nm, ".rdata_m1"}, bus.RDATA_M1, t.ed1);
        end
        if (!t.rn) begin
            chk({nm, ".rst_data"}, bus.RDATA_M0 | bus.RDATA_M1, 32'h0);
            chk({nm, ".rst_id"}, 32'({bus.RID_M1, bus.RID_M0}), 32'h0);
        end
    endtask

    initial begin
        bus.RRESP_S0 = 2'b00;
        bus.RRESP_S1 = 2'b01;
        bus.RRESP_S2 = 2'b10;

        // reset with all slaves requesting
        tbl.push_back(mk(1'b0, 3'b111, 3'b000, 8'h13, 8'h13, 8'h13, 32'h1, 32'h2, 32'h3, 2'b11, 3'b000, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0));
        // single burst S1 RID 8'h13 -> M0 id 3, beats A0..A3
        tbl.push_back(mk(1'b1, 3'b010, 3'b000, 8'h00, 8'h13, 8'h00, 32'h0, 32'hA0, 32'h0, 2'b01, 3'b000, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0));
        tbl.push_back(mk(1'b1, 3'b010, 3'b000, 8'h00, 8'h13, 8'h00, 32'h0, 32'hA0, 32'h0, 2'b01, 3'b010, 2'b01, 2'b00, 4'h3, 4'h0, 32'hA0, 32'h0));
        tbl.push_back(mk(1'b1, 3'b010, 3'b000, 8'h00, 8'h13, 8'h00, 32'h0, 32'hA1, 32'h0, 2'b01, 3'b010, 2'b01, 2'b00, 4'h3, 4'h0, 32'hA1, 32'h0));
        tbl.push_back(mk(1'b1, 3'b010, 3'b000, 8'h00, 8'h13, 8'h00, 32'h0, 32'hA2, 32'h0, 2'b01, 3'b010, 2'b01, 2'b00, 4'h3, 4'h0, 32'hA2, 32'h0));
        tbl.push_back(mk(1'b1, 3'b010, 3'b010, 8'h00, 8'h13, 8'h00, 32'h0, 32'hA3, 32'h0, 2'b01, 3'b010, 2'b01, 2'b01, 4'h3, 4'h0, 32'hA3, 32'h0));
        tbl.push_back(mk(1'b1, 3'b000, 3'b000, 8'h00, 8'h13, 8'h00, 32'h0, 32'hA3, 32'h0, 2'b01, 3'b000, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0));
        // backpressure S0 RID 8'h27 -> M1 id 7, stall row has only M0 ready
        tbl.push_back(mk(1'b1, 3'b001, 3'b000, 8'h27, 8'h00, 8'h00, 32'hB0, 32'h0, 32'h0, 2'b10, 3'b000, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0));
        tbl.push_back(mk(1'b1, 3'b001, 3'b000, 8'h27, 8'h00, 8'h00, 32'hB0, 32'h0, 32'h0, 2'b10, 3'b001, 2'b10, 2'b00, 4'h0, 4'h7, 32'h0, 32'hB0));
        tbl.push_back(mk(1'b1, 3'b001, 3'b001, 8'h27, 8'h00, 8'h00, 32'hB1, 32'h0, 32'h0, 2'b01, 3'b000, 2'b10, 2'b10, 4'h0, 4'h7, 32'h0, 32'hB1));
        tbl.push_back(mk(1'b1, 3'b001, 3'b001, 8'h27, 8'h00, 8'h00, 32'hB1, 32'h0, 32'h0, 2'b10, 3'b001, 2'b10, 2'b10, 4'h0, 4'h7, 32'h0, 32'hB1));
        tbl.push_back(mk(1'b1, 3'b000, 3'b000, 8'h27, 8'h00, 8'h00, 32'hB1, 32'h0, 32'h0, 2'b10, 3'b000, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0));
        // invalid tag S2 RID 8'h35: sunk with no master ready
        tbl.push_back(mk(1'b1, 3'b100, 3'b000, 8'h00, 8'h00, 8'h35, 32'h0, 32'h0, 32'hC0, 2'b00, 3'b000, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0));
        tbl.push_back(mk(1'b1, 3'b100, 3'b000, 8'h00, 8'h00, 8'h35, 32'h0, 32'h0, 32'hC0, 2'b00, 3'b100, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0));
        tbl.push_back(mk(1'b1, 3'b100, 3'b000, 8'h00, 8'h00, 8'h35, 32'h0, 32'h0, 32'hC1, 2'b00, 3'b100, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0));
        tbl.push_back(mk(1'b1, 3'b100, 3'b100, 8'h00, 8'h00, 8'h35, 32'h0, 32'h0, 32'hC2, 2'b00, 3'b100, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0));
        tbl.push_back(mk(1'b1, 3'b000, 3'b000, 8'h00, 8'h00, 8'h35, 32'h0, 32'h0, 32'hC2, 2'b00, 3'b000, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0));
        // slave bubble: S1 (8'h12 -> M0) drops valid while S0 (8'h21 -> M1) waits
        tbl.push_back(mk(1'b1, 3'b010, 3'b000, 8'h21, 8'h12, 8'h00, 32'hE0, 32'hD0, 32'h0, 2'b11, 3'b000, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0));
        tbl.push_back(mk(1'b1, 3'b010, 3'b000, 8'h21, 8'h12, 8'h00, 32'hE0, 32'hD0, 32'h0, 2'b11, 3'b010, 2'b01, 2'b00, 4'h2, 4'h0, 32'hD0, 32'h0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1'b1, 3'b001, 3'b000, 8'h21, 8'h12, 8'h00, 32'hE0, 32'hD0, 32'h0, 2'b11, 3'b010, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0));
        tbl.push_back(mk(1'b1, 3'b011, 3'b010, 8'h21, 8'h12, 8'h00, 32'hE0, 32'hD1, 32'h0, 2'b11, 3'b010, 2'b01, 2'b01, 4'h2, 4'h0, 32'hD1, 32'h0));
        tbl.push_back(mk(1'b1, 3'b001, 3'b001, 8'h21, 8'h12, 8'h00, 32'hE0, 32'hD1, 32'h0, 2'b11, 3'b000, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0));
        tbl.push_back(mk(1'b1, 3'b001, 3'b001, 8'h21, 8'h12, 8'h00, 32'hE0, 32'hD1, 32'h0, 2'b11, 3'b001, 2'b10, 2'b10, 4'h0, 4'h1, 32'h0, 32'hE0));
        tbl.push_back(mk(1'b1, 3'b000, 3'b000, 8'h21, 8'h12, 8'h00, 32'hE0, 32'hD1, 32'h0, 2'b11, 3'b000, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // reset in the middle of a 4-beat S1 burst, then a fresh burst
        apply(mk(1'b1, 3'b010, 3'b000, 8'h00, 8'h13, 8'h00, 32'h0, 32'hF0, 32'h0, 2'b01, 3'b000, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0), "mrst.idle");
        apply(mk(1'b1, 3'b010, 3'b000, 8'h00, 8'h13, 8'h00, 32'h0, 32'hF0, 32'h0, 2'b01, 3'b010, 2'b01, 2'b00, 4'h3, 4'h0, 32'hF0, 32'h0), "mrst.b0");
        apply(mk(1'b1, 3'b010, 3'b000, 8'h00, 8'h13, 8'h00, 32'h0, 32'hF1, 32'h0, 2'b01, 3'b010, 2'b01, 2'b00, 4'h3, 4'h0, 32'hF1, 32'h0), "mrst.b1");
        apply(mk(1'b0, 3'b010, 3'b000, 8'h00, 8'h13, 8'h00, 32'h0, 32'hF2, 32'h0, 2'b01, 3'b000, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0), "mrst.rst");
        apply(mk(1'b1, 3'b010, 3'b000, 8'h00, 8'h13, 8'h00, 32'h0, 32'h50, 32'h0, 2'b01, 3'b000, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0), "mrst.idle2");
        apply(mk(1'b1, 3'b010, 3'b000, 8'h00, 8'h13, 8'h00, 32'h0, 32'h50, 32'h0, 2'b01, 3'b010, 2'b01, 2'b00, 4'h3, 4'h0, 32'h50, 32'h0), "mrst.n0");
        apply(mk(1'b1, 3'b010, 3'b010, 8'h00, 8'h13, 8'h00, 32'h0, 32'h51, 32'h0, 2'b01, 3'b010, 2'b01, 2'b01, 4'h3, 4'h0, 32'h51, 32'h0), "mrst.n1");

        // contention from a fresh reset: S0 (8'h14 -> M0) and S2 (8'h26 -> M1)
        apply(mk(1'b0, 3'b101, 3'b000, 8'h14, 8'h00, 8'h26, 32'h60, 32'h0, 32'h70, 2'b11, 3'b000, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0), "cont.rst");
        apply(mk(1'b1, 3'b101, 3'b000, 8'h14, 8'h00, 8'h26, 32'h60, 32'h0, 32'h70, 2'b11, 3'b000, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0), "cont.idle");
        apply(mk(1'b1, 3'b101, 3'b000, 8'h14, 8'h00, 8'h26, 32'h60, 32'h0, 32'h70, 2'b11, 3'b001, 2'b01, 2'b00, 4'h4, 4'h0, 32'h60, 32'h0), "cont.s0b0");
        apply(mk(1'b1, 3'b101, 3'b101, 8'h14, 8'h00, 8'h26, 32'h61, 32'h0, 32'h70, 2'b11, 3'b001, 2'b01, 2'b01, 4'h4, 4'h0, 32'h61, 32'h0), "cont.s0b1");
        apply(mk(1'b1, 3'b100, 3'b100, 8'h14, 8'h00, 8'h26, 32'h61, 32'h0, 32'h70, 2'b11, 3'b000, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0), "cont.idle2");
        apply(mk(1'b1, 3'b100, 3'b100, 8'h14, 8'h00, 8'h26, 32'h61, 32'h0, 32'h70, 2'b11, 3'b100, 2'b10, 2'b10, 4'h0, 4'h6, 32'h0, 32'h70), "cont.s2");
        apply(mk(1'b1, 3'b010, 3'b010, 8'h14, 8'h11, 8'h26, 32'h0, 32'h80, 32'h0, 2'b11, 3'b000, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0), "cont.idle3");
        apply(mk(1'b1, 3'b010, 3'b010, 8'h14, 8'h11, 8'h26, 32'h0, 32'h80, 32'h0, 2'b11, 3'b010, 2'b01, 2'b01, 4'h1, 4'h0, 32'h80, 32'h0), "cont.s1");
        apply(mk(1'b1, 3'b101, 3'b101, 8'h14, 8'h11, 8'h26, 32'h62, 32'h0, 32'h71, 2'b11, 3'b000, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0), "tie.idle");
`ifdef RDR_RR_ARB_EN
        // pointer sits at S2 after the S1 burst
        apply(mk(1'b1, 3'b101, 3'b101, 8'h14, 8'h11, 8'h26, 32'h62, 32'h0, 32'h71, 2'b11, 3'b100, 2'b10, 2'b10, 4'h0, 4'h6, 32'h0, 32'h71), "tie.first");
        apply(mk(1'b1, 3'b001, 3'b001, 8'h14, 8'h11, 8'h26, 32'h62, 32'h0, 32'h71, 2'b11, 3'b000, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0), "tie.idle2");
        apply(mk(1'b1, 3'b001, 3'b001, 8'h14, 8'h11, 8'h26, 32'h62, 32'h0, 32'h71, 2'b11, 3'b001, 2'b01, 2'b01, 4'h4, 4'h0, 32'h62, 32'h0), "tie.second");
`else
        apply(mk(1'b1, 3'b101, 3'b101, 8'h14, 8'h11, 8'h26, 32'h62, 32'h0, 32'h71, 2'b11, 3'b001, 2'b01, 2'b01, 4'h4, 4'h0, 32'h62, 32'h0), "tie.first");
        apply(mk(1'b1, 3'b100, 3'b100, 8'h14, 8'h11, 8'h26, 32'h62, 32'h0, 32'h71, 2'b11, 3'b000, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0), "tie.idle2");
        apply(mk(1'b1, 3'b100, 3'b100, 8'h14, 8'h11, 8'h26, 32'h62, 32'h0, 32'h71, 2'b11, 3'b100, 2'b10, 2'b10, 4'h0, 4'h6, 32'h0, 32'h71), "tie.second");
`endif
        apply(mk(1'b1, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 32'h0, 32'h0, 32'h0, 2'b11, 3'b000, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0), "tie.end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
